// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: grants the shared RAM data port to the CPU (m0) or a loader (m1).
// Define ARB_STARVE_GUARD_EN to bound m1 starvation at MAX_WAIT denied cycles.
module dmem_port_arbiter #(
    parameter int DWIDTH    = 32,
    parameter int AWIDTH    = 32,
    parameter int MAX_WAIT  = 8,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [AWIDTH-1:0] m0_addr,
    input  logic [3:0]        m0_be,
    input  logic [DWIDTH-1:0] m0_wdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic              m1_lock,
    input  logic [AWIDTH-1:0] m1_addr,
    input  logic [3:0]        m1_be,
    input  logic [DWIDTH-1:0] m1_wdata,
    output logic              m0_gnt,
    output logic              m1_gnt,
    output logic              m0_stall,
    output logic [DWIDTH-1:0] m0_rdata,
    output logic [DWIDTH-1:0] m1_rdata,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [DWIDTH-1:0] mem_wdata,
    output logic              mem_wen,
    input  logic [DWIDTH-1:0] mem_rdata,
    output logic [1:0]        owner
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_M0 = 2'd1, S_M1 = 2'd2} state_t;
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] BMAX = BW'(MAX_BURST);
    state_t          r_owner;
    logic [BW-1:0]   r_burst_cnt;
    logic            w_hold;
    logic            w_force;
    logic            w_m0_gnt;
    logic            w_m1_gnt;
    assign w_hold = (r_owner == S_M1) & m1_req & m1_lock & (r_burst_cnt < BMAX);
`ifdef ARB_STARVE_GUARD_EN
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WMAX = WW'(MAX_WAIT);
    logic [WW-1:0] r_wait_cnt;
    assign w_force = m1_req & (r_wait_cnt == WMAX);
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_wait_cnt <= '0;
        else
            r_wait_cnt <= (m1_req & ~w_m1_gnt) ? ((r_wait_cnt == WMAX) ? WMAX : r_wait_cnt + 1'b1) : '0;
    end
`else
    assign w_force = 1'b0;
`endif
    // Reset gates the grants combinationally so nothing reaches the RAM mid-reset.
    assign w_m1_gnt = ~reset & m1_req & (w_hold | w_force | ~m0_req);
    assign w_m0_gnt = ~reset & m0_req & ~w_hold & ~w_force;
    assign m0_gnt    = w_m0_gnt;
    assign m1_gnt    = w_m1_gnt;
    assign m0_stall  = ~reset & m0_req & ~w_m0_gnt;
    assign m0_rdata  = w_m0_gnt ? mem_rdata : '0;
    assign m1_rdata  = w_m1_gnt ? mem_rdata : '0;
    assign mem_addr  = w_m0_gnt ? m0_addr  : w_m1_gnt ? m1_addr  : '0;
    assign mem_be    = w_m0_gnt ? m0_be    : w_m1_gnt ? m1_be    : '0;
    assign mem_wdata = w_m0_gnt ? m0_wdata : w_m1_gnt ? m1_wdata : '0;
    assign mem_wen   = (w_m0_gnt & m0_we) | (w_m1_gnt & m1_we);
    assign owner     = r_owner;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_owner     <= S_IDLE;
            r_burst_cnt <= '0;
        end else begin
            r_owner     <= w_m1_gnt ? S_M1 : w_m0_gnt ? S_M0 : S_IDLE;
            r_burst_cnt <= ~w_m1_gnt ? '0 : (r_owner != S_M1) ? BW'(1) :
                           (r_burst_cnt == BMAX) ? BMAX : r_burst_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed checks of grant priority, lock bursts, starvation guard and reset.
module tb_dmem_port_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_we, m1_req, m1_we, m1_lock;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [3:0]  m0_be, m1_be;
    logic        m0_gnt, m1_gnt, m0_stall, mem_wen;
    logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic [1:0]  owner;
    logic [31:0] ram [0:63];
    int          n_assert = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    dmem_port_arbiter dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_be(m0_be), .m0_wdata(m0_wdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_be(m1_be),
        .m1_wdata(m1_wdata), .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_stall(m0_stall),
        .m0_rdata(m0_rdata), .m1_rdata(m1_rdata), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_wen(mem_wen), .mem_rdata(mem_rdata), .owner(owner)
    );

    assign mem_rdata = ram[mem_addr[7:2]];
    always @(posedge clk) begin
        if (mem_wen)
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) ram[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ram[i] = '0;
        reset = 1'b1;
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = '0; m0_be = '0; m0_wdata = '0;
        m1_req = 1'b1; m1_we = 1'b1; m1_lock = 1'b0; m1_addr = '0; m1_be = '0; m1_wdata = '0;
        #3;
        chk("rst_m0_gnt", 32'(m0_gnt), 0);
        chk("rst_m1_gnt", 32'(m1_gnt), 0);
        chk("rst_wen", 32'(mem_wen), 0);
        chk("rst_stall", 32'(m0_stall), 0);
        chk("rst_owner", 32'(owner), 0);
        tick;
        tick;
        reset = 1'b0;
        #2;
        chk("post_rst_m0_gnt", 32'(m0_gnt), 1);
        chk("post_rst_m1_gnt", 32'(m1_gnt), 0);
        tick;
        // m0 partial write then read-back
        m1_req = 1'b0; m1_we = 1'b0;
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h40; m0_be = 4'b0011; m0_wdata = 32'hDEADBEEF;
        #2;
        chk("wr_wen", 32'(mem_wen), 1);
        chk("wr_be", 32'(mem_be), 32'h3);
        chk("wr_addr", mem_addr, 32'h40);
        chk("wr_wdata", mem_wdata, 32'hDEADBEEF);
        tick;
        m0_we = 1'b0; m0_be = 4'b1111;
        #2;
        chk("rd_wen", 32'(mem_wen), 0);
        chk("rd_m0_rdata", m0_rdata, 32'h0000BEEF);
        chk("rd_m1_rdata", m1_rdata, 0);
        tick;
        chk("rd_owner", 32'(owner), 1);
        // m0 hogging the port while m1 waits
        m1_req = 1'b1; m1_addr = 32'h40;
`ifdef ARB_STARVE_GUARD_EN
        for (int c = 0; c <= 8; c++) begin
            #2;
            chk($sformatf("guard_m1_gnt_c%0d", c), 32'(m1_gnt), (c == 8) ? 1 : 0);
            if (c == 8) chk("guard_stall", 32'(m0_stall), 1);
            tick;
        end
        chk("guard_wait_clr", 32'(dut.r_wait_cnt), 0);
`else
        for (int c = 0; c < 100; c++) begin
            #2;
            chk($sformatf("noguard_m1_gnt_c%0d", c), 32'(m1_gnt), 0);
            tick;
        end
`endif
        m0_req = 1'b0; m1_req = 1'b0;
        tick;
        chk("idle_owner", 32'(owner), 0);
        // m1 locked read burst starting while m0 idle
        m1_req = 1'b1; m1_lock = 1'b1; m1_we = 1'b0; m1_addr = 32'h40;
        #2;
        chk("burst_first_gnt", 32'(m1_gnt), 1);
        chk("burst_m1_rdata", m1_rdata, 32'h0000BEEF);
        chk("burst_m0_rdata", m0_rdata, 0);
        tick;
        m0_req = 1'b1;
        for (int c = 1; c < 4; c++) begin
            #2;
            chk($sformatf("burst_m1_gnt_%0d", c), 32'(m1_gnt), 1);
            chk($sformatf("burst_stall_%0d", c), 32'(m0_stall), 1);
            tick;
        end
        #2;
        chk("burst_end_m0_gnt", 32'(m0_gnt), 1);
        chk("burst_end_m1_gnt", 32'(m1_gnt), 0);
        tick;
        chk("burst_end_owner", 32'(owner), 1);
        // reset in the third cycle of a write burst
        m0_req = 1'b0; m1_req = 1'b0; m1_lock = 1'b0;
        tick;
        m1_req = 1'b1; m1_lock = 1'b1; m1_we = 1'b1; m1_addr = 32'h80; m1_be = 4'hF;
        m1_wdata = 32'h11223344;
        #2;
        chk("wburst_gnt0", 32'(m1_gnt), 1);
        chk("wburst_wen0", 32'(mem_wen), 1);
        tick;
        #2;
        chk("wburst_gnt1", 32'(m1_gnt), 1);
        tick;
        reset = 1'b1; m0_req = 1'b1;
        #2;
        chk("wburst_rst_wen", 32'(mem_wen), 0);
        chk("wburst_rst_gnt", 32'(m1_gnt), 0);
        chk("wburst_rst_owner", 32'(owner), 0);
        chk("wburst_rst_burst", 32'(dut.r_burst_cnt), 0);
        tick;
        reset = 1'b0;
        #2;
        chk("wburst_restart_m0", 32'(m0_gnt), 1);
        chk("wburst_restart_m1", 32'(m1_gnt), 0);
        chk("wburst_ram", ram[32], 32'h11223344);
        tick;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
